// File: rtl/icu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | icu_pkg : shared types and field positions for the MC14500B-style ICU |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package icu_pkg;

  localparam int OPCODE_WIDTH = 4;
  localparam int OPERAND_LSB  = 0;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_NOPO = 4'h0, OP_LD   = 4'h1, OP_LDC = 4'h2, OP_AND  = 4'h3,
    OP_ANDC = 4'h4, OP_OR   = 4'h5, OP_ORC = 4'h6, OP_XNOR = 4'h7,
    OP_STO  = 4'h8, OP_STOC = 4'h9, OP_IEN = 4'hA, OP_OEN  = 4'hB,
    OP_JMP  = 4'hC, OP_RTN  = 4'hD, OP_SKZ = 4'hE, OP_NOPF = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  // The opcode sits directly above the operand address in the program word.
  function automatic int opcode_lsb(input int size_log);
    return size_log;
  endfunction

endpackage
`default_nettype wire

// File: rtl/icu_logic_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | icu_logic_unit : result-register update for the load/logic opcodes   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module icu_logic_unit
  import icu_pkg::*;
(
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    rr,
  input  logic                    d,
  output logic                    rr_next,
  output logic                    rr_we
);

  always_comb begin
    rr_next = rr;
    rr_we   = 1'b0;
    case (opcode_t'(opcode))
      OP_LD:   begin rr_next = d;           rr_we = 1'b1; end
      OP_LDC:  begin rr_next = ~d;          rr_we = 1'b1; end
      OP_AND:  begin rr_next = rr & d;      rr_we = 1'b1; end
      OP_ANDC: begin rr_next = rr & ~d;     rr_we = 1'b1; end
      OP_OR:   begin rr_next = rr | d;      rr_we = 1'b1; end
      OP_ORC:  begin rr_next = rr | ~d;     rr_we = 1'b1; end
      OP_XNOR: begin rr_next = ~(rr ^ d);   rr_we = 1'b1; end
      default: begin rr_next = rr;          rr_we = 1'b0; end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/icu_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | icu_core : fetch/read/exec/write sequencer of the 1-bit control unit |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module icu_core
  import icu_pkg::*;
#(
  parameter int SIZE_LOG = 8,
  parameter int PROG_LOG = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic [PROG_LOG-1:0]        pc,
  input  logic [SIZE_LOG+3:0]        instr,
  output logic [SIZE_LOG-1:0]        address,
  input  logic                       data_in,
  output logic                       data_out,
  output logic                       write,
  output logic                       rr,
  output logic                       ien,
  output logic                       oen,
  output logic                       jmp,
  output logic                       rtn,
  output logic                       flag_o,
  output logic                       flag_f
);

  localparam int OPC_LSB = opcode_lsb(SIZE_LOG);

  localparam logic [1:0] S_FETCH = FETCH;
  localparam logic [1:0] S_READ  = READ;
  localparam logic [1:0] S_EXEC  = EXEC;
  localparam logic [1:0] S_WRITE = WRITE;

  logic [1:0] state;
  opcode_t    op_q;
  logic       sample;
  logic       skip;

  opcode_t            instr_op;
  logic [SIZE_LOG-1:0] instr_addr;
  logic               d;
  logic               rr_next;
  logic               rr_we;

  assign instr_op   = opcode_t'(instr[OPC_LSB +: OPCODE_WIDTH]);
  assign instr_addr = instr[OPERAND_LSB +: SIZE_LOG];
  assign d          = sample & ien;

  icu_logic_unit u_logic_unit (
    .opcode  (op_q),
    .rr      (rr),
    .d       (d),
    .rr_next (rr_next),
    .rr_we   (rr_we)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      pc       <= '0;
      op_q     <= OP_NOPO;
      address  <= '0;
      sample   <= 1'b0;
      skip     <= 1'b0;
      data_out <= 1'b0;
      write    <= 1'b0;
      rr       <= 1'b0;
      ien      <= 1'b0;
      oen      <= 1'b0;
      jmp      <= 1'b0;
      rtn      <= 1'b0;
      flag_o   <= 1'b0;
      flag_f   <= 1'b0;
    end else begin
      write  <= 1'b0;
      jmp    <= 1'b0;
      rtn    <= 1'b0;
      flag_o <= 1'b0;
      flag_f <= 1'b0;
      case (state)
        S_FETCH: begin
          op_q    <= instr_op;
          address <= instr_addr;
          pc      <= pc + PROG_LOG'(1);
          // RR cannot change during a store, so data_out is set up at fetch
          // and is already settled a full cycle before the strobe rises.
          if (!skip && (instr_op == OP_STO || instr_op == OP_STOC))
            data_out <= rr ^ (instr_op == OP_STOC);
          state   <= S_READ;
        end
        S_READ: begin
          sample <= data_in;
          state  <= S_EXEC;
        end
        S_EXEC: begin
          state <= S_FETCH;
          if (skip) begin
            skip <= 1'b0;
          end else begin
            if (rr_we)
              rr <= rr_next;
            case (op_q)
              OP_NOPO: flag_o <= 1'b1;
              OP_STO, OP_STOC: begin
                if (oen) begin
                  write <= 1'b1;
                  state <= S_WRITE;
                end
              end
              OP_IEN:  ien <= sample;
              OP_OEN:  oen <= sample;
              OP_JMP: begin
                pc  <= PROG_LOG'(address);
                jmp <= 1'b1;
              end
              OP_RTN: begin
                rtn  <= 1'b1;
                skip <= 1'b1;
              end
              OP_SKZ:  skip <= ~rr;
              OP_NOPF: flag_f <= 1'b1;
              default: ;
            endcase
          end
        end
        S_WRITE: state <= S_FETCH;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/icu_core.md
# icu_core

Sequencing core of the MC14500B-style 1-bit industrial control unit. Fetches 4-bit-opcode instructions from program memory, performs reads and strobed writes on the 1-bit data RAM/IO bus, maintains the result register (RR) and the input/output enables, and emits the JMP/RTN/FLAG pulses. It is the initiator for the data RAM: it drives `address`, `data_out` and the `write` strobe; the RAM returns `data_in`.

## Interface
- `SIZE_LOG`, 8: data address width; must match the data RAM.
- `PROG_LOG`, 8: program counter width.
- `clock`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `pc`  out  PROG_LOG  program memory address.
- `instr`  in  SIZE_LOG+4  program word: [SIZE_LOG+3:SIZE_LOG] opcode, [SIZE_LOG-1:0] operand address.
- `address`  out  SIZE_LOG  data bus address.
- `data_in`  in  1  read data from the RAM.
- `data_out`  out  1  write data to the RAM.
- `write`  out  1  write strobe; the RAM captures on its rising edge.
- `rr`  out  1  result register.
- `ien`, `oen`  out  1 each  input and output enable registers.
- `jmp`, `rtn`, `flag_o`, `flag_f`  out  1 each  one-cycle pulses.

## Operation
- FSM states: FETCH, READ, EXEC, WRITE. The FSM always starts each instruction in FETCH.
- FETCH: `pc` is stable. At the clock edge, latch `instr` into the instruction register, increment `pc` (wraps modulo 2^PROG_LOG), and go to READ.
- READ: `address` is driven from the latched operand. At the clock edge, sample `data_in` into the operand bit and go to EXEC.
- Effective operand: `d = data_in_sampled & ien`.
- EXEC, by opcode:
  - 0 NOPO: pulse `flag_o`.
  - 1 LD: RR=d. 2 LDC: RR=~d.
  - 3 AND: RR&=d. 4 ANDC: RR&=~d.
  - 5 OR: RR|=d. 6 ORC: RR|=~d.
  - 7 XNOR: RR=~(RR^d).
  - 8 STO: `data_out`=RR. 9 STOC: `data_out`=~RR.
  - A IEN: ien=raw `data_in`. B OEN: oen=raw `data_in`. Both use the raw sample, not gated by IEN.
  - C JMP: pc=operand, zero-extended or truncated to PROG_LOG. Pulse `jmp`.
  - D RTN: pulse `rtn` and set skip.
  - E SKZ: set skip if RR==0.
  - F NOPF: pulse `flag_f`.
- Next state after EXEC: WRITE for STO/STOC when oen=1; otherwise FETCH. STO/STOC with oen=0 completes with no strobe.
- WRITE: `write`=1 for exactly one cycle, then go to FETCH.
- Skip: the instruction fetched while skip=1 is a full no-op in EXEC. This means no RR/IEN/OEN change, no pulses, no WRITE, and no JMP. Skip clears at the end of that EXEC. A skipped SKZ or RTN does not re-arm skip.

## Timing
- Latency per instruction:
  - 3 cycles for all instructions except STO/STOC with oen=1.
  - 4 cycles for STO/STOC with oen=1.
- All outputs are registered.
- `address` and `data_out` are stable from READ through the cycle after WRITE. `write` rises only after both have been stable for at least one cycle.
- Pulse outputs are high for the single cycle following the EXEC edge.
- Reset values: pc=0, state=FETCH, `address`=0, `data_out`=0, `write`=0, rr=0, ien=0, oen=0, skip=0, all pulses 0.
- Reset asserted mid-instruction, including during WRITE, drops `write` immediately. No partial state survives.
- JMP to the current address produces a 3-cycle loop. A JMP at pc=2^PROG_LOG−1 behaves the same as elsewhere.

## Structure
- Package `icu_pkg`:
  - `opcode_t` enum covering the 16 codes above.
  - `state_t` enum {FETCH, READ, EXEC, WRITE}.
  - Opcode field position constants.
- Sub-module `icu_logic_unit`: combinational. Inputs: opcode, rr, d. Outputs: next rr, rr_we. Instantiated once in `icu_core`.

## Test plan
- Reset then program {A:05, B:05, 1:06, 8:00}, RAM[5]=1, input bit [06]=1 → ien=1, oen=1, rr=1. `write` pulses once with address=0x00, data_out=1, on cycle 13 after reset release.
- Same program with the B instruction replaced by NOPO → `flag_o` pulses once. STO completes in 3 cycles with `write` never asserted.
- ien=1, RR=1; XNOR with d=0 → rr=0. Next instruction is SKZ, followed by LDC of a 0 bit → LDC is skipped and rr stays 0. The instruction after that executes normally.
- JMP 0x10 at pc=0x03 → `jmp` pulses for one cycle and the next FETCH shows pc=0x10. With PROG_LOG=4, JMP 0x1F loads pc=0xF.
- RTN followed by JMP 0x00 → `rtn` pulses, the JMP is skipped (no `jmp` pulse), and pc continues sequentially.
- Assert `reset` during the WRITE cycle → `write` deasserts asynchronously in the same cycle. After release, pc=0 and rr=ien=oen=0.
